inst_mem_loader: RTL

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
// Byte-stream instruction-memory loader: parses [N_hi N_lo][4*N payload][xor csum],
// writes big-endian words to instruction memory and holds the CPU in reset until verified.
module inst_mem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic          reload,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data,
    output logic          cpu_rst,
    output logic          load_done,
    output logic          load_err
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] LP_DEPTH = 16'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [15:0]   r_cnt;
    logic [15:0]   r_widx;
    logic [1:0]    r_bidx;
    logic [23:0]   r_shift;
    logic [7:0]    r_csum;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_data;
    logic          r_cpu_rst;
    logic          r_done;
    logic          r_err;

    logic          w_ready;
    logic          w_xfer;
    logic [15:0]   w_n;
    logic          w_last_word;

    assign w_ready     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                         (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_xfer      = byte_valid & w_ready;
    assign w_n         = {r_cnt[15:8], byte_data};
    assign w_last_word = (r_bidx == 2'd3) && (r_widx == (r_cnt - 16'd1));

    assign byte_ready = w_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign cpu_rst    = r_cpu_rst;
    assign load_done  = r_done;
    assign load_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_LEN_HI;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN_HI: if (w_xfer) w_state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_n == 16'd0)         w_state_nxt = S_CSUM;
                    else if (w_n > LP_DEPTH)  w_state_nxt = S_ERR;
                    else                      w_state_nxt = S_DATA;
                end
            end
            S_DATA:   if (w_xfer && w_last_word) w_state_nxt = S_CSUM;
            S_CSUM: begin
                if (w_xfer) w_state_nxt = (byte_data == r_csum) ? S_DONE : S_ERR;
            end
            S_DONE:   if (reload) w_state_nxt = S_LEN_HI;
            S_ERR:    w_state_nxt = S_ERR;
            default:  w_state_nxt = S_ERR;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_widx     <= '0;
            r_bidx     <= '0;
            r_shift    <= '0;
            r_csum     <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_we  <= 1'b0;
            r_cpu_rst <= (w_state_nxt != S_DONE);
            r_done    <= (w_state_nxt == S_DONE);
            r_err     <= (w_state_nxt == S_ERR);
            case (r_state)
                S_LEN_HI: if (w_xfer) r_cnt[15:8] <= byte_data;
                S_LEN_LO: if (w_xfer) r_cnt[7:0]  <= byte_data;
                S_DATA: begin
                    if (w_xfer) begin
                        r_shift <= {r_shift[15:0], byte_data};
                        r_csum  <= r_csum ^ byte_data;
                        r_bidx  <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_mem_we   <= 1'b1;
                            r_mem_data <= {r_shift, byte_data};
                            r_mem_addr <= AW'(r_widx);
                            r_widx     <= r_widx + 16'd1;
                        end
                    end
                end
                S_DONE: begin
                    // Restart a fresh image; mem_data keeps the last written word.
                    if (reload) begin
                        r_cnt      <= '0;
                        r_widx     <= '0;
                        r_bidx     <= '0;
                        r_shift    <= '0;
                        r_csum     <= '0;
                        r_mem_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
